// File: rtl/dac_feeder_pkg.sv
// rtl/dac_feeder_pkg.sv - shared FSM state type and timing constants for the DAC wave feeder
package dac_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_SETTLE,
        ST_DRAIN
    } feeder_state_e;

    localparam int SETTLE_CYCLES = 3;
    localparam int PIPE_DEPTH    = 2;

endpackage

// File: rtl/wave_addr_gen.sv
// rtl/wave_addr_gen.sv - waveform address generator with pass wrap and last-sample detection
module wave_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W-1:0] length_in,
    input  logic [7:0]        loop_in,
    output logic [ADDR_W-1:0] addr,
    output logic              pass_end,
    output logic              last
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        passes_q, passes_d;
    logic              inf_q, inf_d;

    assign addr     = base_q + idx_q;
    assign pass_end = (idx_q == len_q - ADDR_W'(1));
    assign last     = pass_end && !inf_q && (passes_q == 8'd1);

    // Load a new waveform on start; advance the index per read, wrapping at the end of each pass.
    always_comb begin
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        passes_d = passes_q;
        inf_d    = inf_q;
        if (load) begin
            base_d   = base_in;
            len_d    = length_in;
            idx_d    = '0;
            passes_d = loop_in;
            inf_d    = (loop_in == 8'd0);
        end else if (step) begin
            if (pass_end) begin
                idx_d = '0;
                if (!inf_q) begin
                    passes_d = passes_q - 8'd1;
                end
            end else begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            passes_q <= '0;
            inf_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            passes_q <= passes_d;
            inf_q    <= inf_d;
        end
    end

endmodule

// File: rtl/dac_wave_feeder.sv
// rtl/dac_wave_feeder.sv - bursts waveform samples from sample RAM into the DAC input FIFO
module dac_wave_feeder #(
    parameter int ADDR_W  = 10,
    parameter int DW      = 10,
    parameter int BURST_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  length,
    input  logic [7:0]         loop_count,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               fmt_signed,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DW-1:0]      mem_rdata,
    input  logic               dac_low,
    input  logic               dac_empty,
    output logic               dac_wr,
    output logic [DW-1:0]      dac_data,
    output logic               busy,
    output logic               done,
    output logic               underrun
);

    import dac_feeder_pkg::*;

    feeder_state_e        state_q, state_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BURST_W-1:0]   bcnt_q, bcnt_d;
    logic [1:0]           scnt_q, scnt_d;
    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    logic [DW-1:0]        data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 underrun_q, underrun_d;
    logic                 wrote_q, wrote_d;
    logic                 gen_load, gen_step, gen_last;
    logic                 gen_pass_end;

    wave_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (gen_load),
        .step      (gen_step),
        .base_in   (base_addr),
        .length_in (length),
        .loop_in   (loop_count),
        .addr      (mem_addr),
        .pass_end  (gen_pass_end),
        .last      (gen_last)
    );

    assign mem_rd   = (state_q == ST_BURST);
    assign dac_wr   = vld_q[PIPE_DEPTH-1];
    assign dac_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

    // Playback FSM, read pipeline, sample format conversion and underrun tracking.
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        bcnt_d     = bcnt_q;
        scnt_d     = scnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        wrote_d    = wrote_q | dac_wr;
        gen_load   = 1'b0;
        gen_step   = 1'b0;
        vld_d      = {vld_q[PIPE_DEPTH-2:0], mem_rd};
        data_d     = data_q;
        if (vld_q[0]) begin
            data_d = fmt_signed ? {~mem_rdata[DW-1], mem_rdata[DW-2:0]} : mem_rdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (length != '0)) begin
                    state_d    = ST_WAIT;
                    gen_load   = 1'b1;
                    burst_d    = (burst_len == '0) ? BURST_W'(1) : burst_len;
                    busy_d     = 1'b1;
                    underrun_d = 1'b0;
                    wrote_d    = 1'b0;
                end
            end
            ST_WAIT: begin
                bcnt_d = '0;
                if (stop) begin
                    state_d = ST_DRAIN;
                end else if (dac_low) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                gen_step = 1'b1;
                bcnt_d   = bcnt_q + BURST_W'(1);
                if (stop || gen_last) begin
                    state_d = ST_DRAIN;
                end else if (bcnt_q == burst_q - BURST_W'(1)) begin
                    state_d = ST_SETTLE;
                    scnt_d  = '0;
                end
            end
            ST_SETTLE: begin
                scnt_d = scnt_q + 2'd1;
                if (stop) begin
                    state_d = ST_DRAIN;
                end else if (scnt_q == 2'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (!vld_q[0]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q == ST_WAIT || state_q == ST_BURST || state_q == ST_SETTLE)
            && dac_empty && wrote_q) begin
            underrun_d = 1'b1;
        end
    end

    // State and output registers; reset drops any in-flight samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            burst_q    <= '0;
            bcnt_q     <= '0;
            scnt_q     <= '0;
            vld_q      <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            wrote_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            bcnt_q     <= bcnt_d;
            scnt_q     <= scnt_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            wrote_q    <= wrote_d;
        end
    end

endmodule

// File: tb/tb_dac_wave_feeder.sv
// tb/tb_dac_wave_feeder.sv - scoreboard bench for dac_wave_feeder
module tb_dac_wave_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop;
    logic [9:0] base_addr, length;
    logic [7:0] loop_count;
    logic [4:0] burst_len;
    logic       fmt_signed;
    logic       mem_rd;
    logic [9:0] mem_addr;
    logic [9:0] mem_rdata = '0;
    logic       dac_low, dac_empty;
    logic       dac_wr;
    logic [9:0] dac_data;
    logic       busy, done, underrun;

    dac_wave_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .base_addr  (base_addr),
        .length     (length),
        .loop_count (loop_count),
        .burst_len  (burst_len),
        .fmt_signed (fmt_signed),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .dac_low    (dac_low),
        .dac_empty  (dac_empty),
        .dac_wr     (dac_wr),
        .dac_data   (dac_data),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    logic [9:0] ram [0:1023];
    always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [9:0] exp_addr_q[$];
    logic [9:0] exp_data_q[$];
    int         stamp_q[$];
    int         runs_q[$];
    int         gaps_q[$];
    int         rd_count = 0;
    int         wr_count = 0;
    int         last_wr_cyc = 0;
    int         last_rd_cyc = -100;
    int         cur_run = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd) begin
                rd_count++;
                if (exp_addr_q.size() == 0) check("extra_rd", 1, 0);
                else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                stamp_q.push_back(cyc + 2);
                if (last_rd_cyc == cyc - 1) cur_run++;
                else begin
                    if (cur_run > 0) runs_q.push_back(cur_run);
                    gaps_q.push_back(cyc - last_rd_cyc - 1);
                    cur_run = 1;
                end
                last_rd_cyc = cyc;
            end
            if (dac_wr) begin
                wr_count++;
                last_wr_cyc = cyc;
                if (exp_data_q.size() == 0 || stamp_q.size() == 0) check("extra_wr", 1, 0);
                else begin
                    check("dac_data", 32'(dac_data), 32'(exp_data_q.pop_front()));
                    check("wr_latency", cyc, stamp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [9:0] fmt_model(input logic [9:0] d, input logic s);
        return s ? {~d[9], d[8:0]} : d;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [9:0] a, input logic [9:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic start_run(input logic [9:0] b, input logic [9:0] l, input logic [7:0] lc,
                             input logic [4:0] bl);
        base_addr  = b;
        length     = l;
        loop_count = lc;
        burst_len  = bl;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic prog(input logic [9:0] b, input logic [9:0] l, input logic [7:0] lc,
                        input logic [4:0] bl, input int npush);
        logic [9:0] a;
        for (int i = 0; i < npush; i++) begin
            a = b + 10'(i % int'(l));
            push_exp(a, fmt_model(ram[a], fmt_signed));
        end
        start_run(b, l, lc, bl);
    endtask

    task automatic wait_done(input string tag, input int budget, output int dcyc);
        logic found = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                found = 1'b1;
                dcyc  = cyc;
                break;
            end
        end
        check(tag, 32'(found), 1);
    endtask

    task automatic wait_reads(input string tag, input int target, input int budget);
        logic hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rd_count >= target) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(hit), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dcyc, rd0, wr0;
        for (int i = 0; i < 1024; i++) ram[i] = 10'($urandom);
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        base_addr = '0; length = '0; loop_count = '0; burst_len = '0;
        fmt_signed = 1'b0; dac_low = 1'b0; dac_empty = 1'b0;
        repeat (3) tick();
        check("reset_outs", {mem_rd, mem_addr, dac_wr, dac_data, busy, done, underrun}, 0);
        rst = 1'b0;
        tick();

        // 1: single pass, whole waveform in one burst
        dac_low = 1'b1;
        wr0 = wr_count;
        prog(10'h010, 10'd4, 8'd1, 5'd8, 4);
        check("t1_busy", 32'(busy), 1);
        wait_done("t1_done_seen", 60, dcyc);
        check("t1_done_lat", dcyc, last_wr_cyc + 1);
        check("t1_busy_at_done", 32'(busy), 0);
        check("t1_wr_count", wr_count - wr0, 4);
        tick();
        check("t1_done_pulse", 32'(done), 0);

        // 2: address wrap, two passes, bursts of 3 with settle gaps
        runs_q.delete(); gaps_q.delete(); cur_run = 0;
        prog(10'h3FE, 10'd4, 8'd2, 5'd3, 8);
        wait_done("t2_done_seen", 100, dcyc);
        runs_q.push_back(cur_run); cur_run = 0;
        check("t2_nruns", runs_q.size(), 3);
        if (runs_q.size() == 3) begin
            check("t2_run0", runs_q[0], 3);
            check("t2_run1", runs_q[1], 3);
            check("t2_run2", runs_q[2], 2);
        end
        check("t2_ngaps", gaps_q.size(), 3);
        if (gaps_q.size() == 3) begin
            check("t2_gap1", gaps_q[1], 4);
            check("t2_gap2", gaps_q[2], 4);
        end

        // 3: signed format MSB inversion at the boundary codes
        ram[10'h020] = 10'h200;
        ram[10'h021] = 10'h1FF;
        fmt_signed = 1'b1;
        push_exp(10'h020, 10'h000);
        push_exp(10'h021, 10'h3FF);
        start_run(10'h020, 10'd2, 8'd1, 5'd4);
        wait_done("t3_done_seen", 60, dcyc);
        fmt_signed = 1'b0;

        // 4: infinite loop aborted after 10 reads
        rd0 = rd_count; wr0 = wr_count;
        prog(10'h100, 10'd3, 8'd0, 5'd4, 10);
        wait_reads("t4_reads_reached", rd0 + 10, 200);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t4_done_seen", 60, dcyc);
        check("t4_rd_count", rd_count - rd0, 10);
        check("t4_wr_count", wr_count - wr0, 10);

        // 5: FIFO never drops low again, then empties -> sticky underrun
        rd0 = rd_count;
        prog(10'h000, 10'd20, 8'd1, 5'd4, 4);
        wait_reads("t5_reads_reached", rd0 + 4, 100);
        dac_low = 1'b0;
        repeat (12) tick();
        check("t5_busy_waiting", 32'(busy), 1);
        check("t5_no_underrun", 32'(underrun), 0);
        check("t5_rd_count", rd_count - rd0, 4);
        dac_empty = 1'b1;
        tick();
        check("t5_underrun_set", 32'(underrun), 1);
        dac_empty = 1'b0;
        repeat (3) tick();
        check("t5_underrun_sticky", 32'(underrun), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t5_done_seen", 30, dcyc);
        dac_low = 1'b1;

        // 6a: zero length start is ignored and does not clear underrun
        rd0 = rd_count;
        start_run(10'h000, 10'd0, 8'd1, 5'd4);
        repeat (3) tick();
        check("t6_len0_busy", 32'(busy), 0);
        check("t6_len0_underrun", 32'(underrun), 1);
        // 6b: start together with stop is ignored
        stop = 1'b1;
        start_run(10'h000, 10'd4, 8'd1, 5'd4);
        stop = 1'b0;
        check("t6_startstop_busy", 32'(busy), 0);
        repeat (3) tick();
        check("t6_startstop_rd", rd_count - rd0, 0);
        // accepted start clears underrun
        prog(10'h040, 10'd2, 8'd1, 5'd2, 2);
        check("t5_underrun_cleared", 32'(underrun), 0);
        wait_done("t5b_done_seen", 60, dcyc);

        // 6c: reset in the middle of a burst
        rd0 = rd_count;
        prog(10'h050, 10'd16, 8'd1, 5'd16, 16);
        wait_reads("t6_reads_reached", rd0 + 5, 100);
        rst = 1'b1;
        tick();
        check("t6_rst_outs", {mem_rd, mem_addr, dac_wr, dac_data, busy, done, underrun}, 0);
        exp_addr_q.delete(); exp_data_q.delete(); stamp_q.delete();
        wr0 = wr_count;
        rst = 1'b0;
        repeat (6) tick();
        check("t6_no_wr_after_rst", wr_count - wr0, 0);
        check("t6_idle_after_rst", 32'(busy), 0);

        check("sb_addr_empty", exp_addr_q.size(), 0);
        check("sb_data_empty", exp_data_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
